// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared types and constants for the HI/LO multiply/divide sequencer
package muldiv_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] doubleword_t;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_MADD  = 4'd3,
        MDU_MADDU = 4'd4,
        MDU_MSUB  = 4'd5,
        MDU_MSUBU = 4'd6,
        MDU_DIV   = 4'd7,
        MDU_DIVU  = 4'd8,
        MDU_MTHI  = 4'd9,
        MDU_MTLO  = 4'd10
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    localparam word_t MDU_DIV0_LO = 32'hFFFF_FFFF;

    function automatic word_t abs32(input word_t x);
        return x[31] ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// rtl/muldiv_ctrl_div_iter.sv - unsigned 32/32 restoring divider, one quotient bit per cycle
module div_iter
    import muldiv_ctrl_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        abort,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    localparam int CW = $clog2(DIV_ITER + 1);

    logic [CW-1:0] r_cnt;
    word_t         r_quot;
    word_t         r_rem;
    word_t         r_div;

    logic [32:0]   w_shift;
    logic [32:0]   w_diff;
    logic          w_ge;

    assign w_shift = {r_rem, r_quot[31]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[32];

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else if (start) begin
            r_cnt  <= CW'(DIV_ITER);
            r_quot <= dividend;
            r_rem  <= '0;
            r_div  <= divisor;
        end else if (r_cnt != '0) begin
            r_rem  <= w_ge ? w_diff[31:0] : w_shift[31:0];
            r_quot <= {r_quot[30:0], w_ge};
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // done marks the final iteration; quot/rem hold the result from the next cycle on
    assign done = (r_cnt == CW'(1));
    assign quot = r_quot;
    assign rem  = r_rem;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage HI/LO sequencer: pipelined multiply, iterative divide, MTHI/MTLO
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic [63:0] hilo_rdata,
    output logic        stall,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata
);

    mdu_state_t  r_state;
    mdu_op_t     r_op;
    logic [7:0]  r_cnt;
    word_t       r_a;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    doubleword_t r_prod [MULT_LAT];

    mdu_op_t     w_op;
    logic        w_is_mt, w_is_mul, w_is_div, w_mul_signed, w_accept;
    logic        w_mul_last, w_div_start, w_div_done;
    doubleword_t w_a_ext, w_b_ext, w_product, w_mul_data, w_div_data;
    word_t       w_a_abs, w_b_abs, w_quot, w_rem;
    logic        w_we, w_stall;
    doubleword_t w_data;

    assign w_op         = mdu_op_t'(op);
    assign w_is_mt      = (w_op == MDU_MTHI) || (w_op == MDU_MTLO);
    assign w_is_mul     = (w_op >= MDU_MULT) && (w_op <= MDU_MSUBU);
    assign w_is_div     = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
    assign w_mul_signed = (w_op == MDU_MULT) || (w_op == MDU_MADD) || (w_op == MDU_MSUB);
    assign w_accept     = (r_state == ST_IDLE) && op_valid && !flush && (w_is_mt || w_is_mul || w_is_div);

    // Low 64 bits of a 64x64 product of sign/zero-extended operands is the exact 32x32 product
    assign w_a_ext   = w_mul_signed ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
    assign w_b_ext   = w_mul_signed ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
    assign w_product = w_a_ext * w_b_ext;

    assign w_a_abs     = (w_op == MDU_DIV) ? abs32(src_a) : src_a;
    assign w_b_abs     = (w_op == MDU_DIV) ? abs32(src_b) : src_b;
    assign w_div_start = w_accept && w_is_div && (src_b != 32'b0);
    assign w_mul_last  = (r_state == ST_MUL) && (r_cnt == 8'(MULT_LAT));

    div_iter #(.DIV_ITER(DIV_ITER)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (w_a_abs),
        .divisor  (w_b_abs),
        .abort    (flush),
        .done     (w_div_done),
        .quot     (w_quot),
        .rem      (w_rem)
    );

    always_comb begin
        w_mul_data = r_prod[MULT_LAT-1];
        case (r_op)
            MDU_MADD, MDU_MADDU: w_mul_data = hilo_rdata + r_prod[MULT_LAT-1];
            MDU_MSUB, MDU_MSUBU: w_mul_data = hilo_rdata - r_prod[MULT_LAT-1];
            default:             w_mul_data = r_prod[MULT_LAT-1];
        endcase
    end

    assign w_div_data = r_div0 ? {r_a, MDU_DIV0_LO}
                               : {(r_neg_r ? -w_rem : w_rem), (r_neg_q ? -w_quot : w_quot)};

    always_comb begin
        w_we    = 1'b0;
        w_stall = 1'b0;
        w_data  = '0;
        if (!rst && !flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mt) begin
                        w_we   = 1'b1;
                        w_data = (w_op == MDU_MTHI) ? {src_a, hilo_rdata[31:0]}
                                                    : {hilo_rdata[63:32], src_a};
                    end else if (w_accept) begin
                        w_stall = 1'b1;
                    end
                end
                ST_MUL: begin
                    if (w_mul_last) begin
                        w_we   = 1'b1;
                        w_data = w_mul_data;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                ST_DIV:  w_stall = 1'b1;
                ST_DONE: begin
                    w_we   = 1'b1;
                    w_data = w_div_data;
                end
                default: w_stall = 1'b0;
            endcase
        end
    end

    assign stall      = w_stall;
    assign hilo_we    = w_we;
    assign hilo_wdata = w_data;
    assign busy       = !rst && (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) r_prod[i] <= '0;
        end else begin
            r_prod[0] <= w_product;
            for (int i = 1; i < MULT_LAT; i++) r_prod[i] <= r_prod[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= MDU_NOP;
            r_cnt   <= '0;
            r_a     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_is_mt) begin
                        r_op  <= w_op;
                        r_cnt <= 8'd1;
                        r_a   <= src_a;
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_neg_q <= (w_op == MDU_DIV) && (src_a[31] ^ src_b[31]);
                            r_neg_r <= (w_op == MDU_DIV) && src_a[31];
                            r_div0  <= (src_b == 32'b0);
                            r_state <= (src_b == 32'b0) ? ST_DONE : ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_last) r_state <= ST_IDLE;
                    else            r_cnt   <= r_cnt + 8'd1;
                end
                ST_DIV: begin
                    if (w_div_done) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with directed vectors
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [63:0] hilo_rdata;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [63:0] hilo_wdata;

    muldiv_ctrl #(.MULT_LAT(2), .DIV_ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .hilo_rdata (hilo_rdata),
        .stall      (stall),
        .busy       (busy),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hilo_we !== 1'b0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: hilo_we=%b wdata=%h at cycle %0d, expected no write",
                         hilo_we, hilo_wdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("write_data", hilo_wdata, mon_e.data);
            end
        end
    end

    // Drives one instruction held in EX until stall drops; must be called just after a posedge
    task automatic issue(input string name, input mdu_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp);
        int  n = 0;
        bit  released = 0;
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        sb.push_back('{cyc + lat, exp});
        for (int k = 0; k < 200 && !released; k++) begin
            @(negedge clk);
            if (stall) n++;
            else       released = 1;
        end
        if (!released) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: stall still 1 after 200 cycles, expected release", name);
        end
        check({name, "_stall_cycles"}, 64'(n), 64'(lat));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = MDU_NOP;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        op_valid   = 1'b1;
        op         = MDU_MULT;
        src_a      = 32'd5;
        src_b      = 32'd6;
        flush      = 1'b0;
        hilo_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_we", 64'(hilo_we), 64'd0);
        check("reset_wdata", hilo_wdata, 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        op_valid = 1'b0;
        op       = MDU_NOP;
        @(posedge clk);
        #1;

        issue("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 2, 64'hFFFF_FFFF_FFFF_FFFA);
        issue("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 2, 64'h0000_0002_FFFF_FFFA);
        issue("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        issue("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        issue("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000);
        issue("div_m100_m7", MDU_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 64'hFFFF_FFFE_0000_000E);
        issue("divu_by0", MDU_DIVU, 32'd5, 32'd0, 1, 64'h0000_0005_FFFF_FFFF);
        issue("div_by0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 1, 64'hFFFF_FFF9_FFFF_FFFF);

        hilo_rdata = 64'h0000_0000_FFFF_FFFF;
        issue("maddu_carry", MDU_MADDU, 32'd1, 32'd1, 2, 64'h0000_0001_0000_0000);
        hilo_rdata = 64'h0;
        issue("msub_wrap", MDU_MSUB, 32'd1, 32'd1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("madd_negneg", MDU_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 64'h1);
        hilo_rdata = 64'h0000_000A_0000_0000;
        issue("msubu", MDU_MSUBU, 32'd2, 32'd3, 2, 64'h0000_0009_FFFF_FFFA);

        hilo_rdata = 64'h1111_1111_2222_2222;
        issue("mthi", MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 0, 64'hDEAD_BEEF_2222_2222);
        issue("mtlo", MDU_MTLO, 32'hCAFE_F00D, 32'd0, 0, 64'h1111_1111_CAFE_F00D);

        // flush mid-divide, then an MTLO straight after
        op_valid = 1'b1;
        op       = MDU_DIV;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("flush_pre_stall", 64'(stall), 64'd1);
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        op    = MDU_MTLO;
        src_a = 32'h0BAD_F00D;
        sb.push_back('{cyc, 64'h1111_1111_0BAD_F00D});
        @(negedge clk);
        check("flush_after_busy", 64'(busy), 64'd0);
        check("flush_after_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = MDU_NOP;

        // flush in IDLE blocks acceptance
        op_valid = 1'b1;
        op       = MDU_MTHI;
        flush    = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        op    = MDU_NOP;
        @(negedge clk);
        check("nop_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        check("nop_busy", 64'(busy), 64'd0);

        // reset in the middle of a divide: no write may follow
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = MDU_DIV;
        src_a    = 32'd50;
        src_b    = 32'd3;
        repeat (5) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = MDU_NOP;
        @(negedge clk);
        check("rst_mid_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        issue("mult_after_rst", MDU_MULT, 32'd7, 32'hFFFF_FFFD, 2, 64'hFFFF_FFFF_FFFF_FFEB);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
